// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, widths and helpers for the LED blink blocks
// Contents:
//   led_state_t : blink sequencer state (2 bits)
//   CODE_W      : width of one requester's blink count
//   clog2()     : counter width for a given modulus (never less than 1)
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_t;

    localparam int CODE_W = 4;

    // Bits needed to hold 0..v-1; clamped to 1 so degenerate moduli still
    // give a legal vector width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// rtl/led_blink_arbiter_if.sv - requester/LED bundle for the blink arbiter
// Signals:
//   req   : level request, bit i = requester i
//   code  : blink count for requester i at [4i+3:4i]
//   LED   : registered LED drive, 1 = lit
//   grant : one-hot owner of the LED, 0 when idle
//   busy  : high while a code is playing
//   done  : one-cycle pulse when a grant ends
// Modports: master = requester side, slave = arbiter side.
interface led_blink_arbiter_if #(
    parameter int N_REQ = 4
);
    import led_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [CODE_W*N_REQ-1:0] code;
    logic                    LED;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    done;

    modport master (
        output req, code,
        input  LED, grant, busy, done
    );

    modport slave (
        input  req, code,
        output LED, grant, busy, done
    );

endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing one tick every CLK_DIV cycles
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   clear    : synchronous restart of the count at 0
//   tick     : high for the last cycle of each CLK_DIV-cycle period
module led_tick_gen
    import led_pkg::*;
#(
    parameter int CLK_DIV = 5000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - round-robin sharing of one LED for blink codes
// Ports:
//   CLOCK_50 : system clock, all logic on posedge
//   reset    : synchronous, active-high
//   bus      : slave side of led_blink_arbiter_if (req/code in,
//              LED/grant/busy/done out, all outputs registered)
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int CLK_DIV   = 5000,
    parameter int GAP_TICKS = 4,
    parameter int N_REQ     = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    led_blink_arbiter_if.slave   bus
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int GAP_W = clog2(GAP_TICKS + 1);

    led_state_t        state_q, state_d;
    logic [CODE_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              led_q, led_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick;
    logic              found;
    logic [PTR_W-1:0]  winner;
    logic [CODE_W-1:0] win_code;

    // Holding the prescaler at 0 throughout IDLE means the first phase of a
    // grant starts from a fresh count, so every phase is exactly CLK_DIV long.
    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (state_q == ST_IDLE),
        .tick     (tick)
    );

    // First set request at or above rr_q, wrapping past the top index.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign win_code = bus.code[int'(winner)*CODE_W +: CODE_W];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
            rr_q        <= '0;
            led_q       <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            rr_q        <= rr_d;
            led_q       <= led_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        rr_d        = rr_q;
        led_d       = led_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                led_d   = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
                if (found) begin
                    remaining_d = win_code;
                    grant_d     = N_REQ'(1) << winner;
                    busy_d      = 1'b1;
                    rr_d        = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    gap_d       = '0;
                    // A zero code still owns the LED for the dark gap.
                    if (win_code != '0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_ON: begin
                if (tick) begin
                    state_d     = ST_OFF;
                    led_d       = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (remaining_q != '0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.LED   = led_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
